display_page_select: RTL
========================

Name: display_page_select

Overview:
- Upstream feeder for the eight 7-segment hex decoders on the processor board.
- Selects one of three debug "pages" of processor state: PC/IR/FSM state, ALU operands, or ALU result.
- Slices the selected page into eight registered 4-bit nibbles, each with a per-digit blank flag.
- The page advances on each debounced press of a board push-button.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples needed to accept a button level change (10 ms at 50 MHz).
- NUM_PAGES, 3, number of display pages; the page index wraps from NUM_PAGES-1 back to 0.

Ports:
- Clk  input  1  system clock, rising-edge.
- ResetN  input  1  reset, asynchronous assert, active-low.
- PageBtnN  input  1  raw push-button, active-low, asynchronous to Clk.
- PC  input  8  program counter.
- IR  input  16  instruction register.
- State  input  4  control FSM state code.
- ALU_A  input  16  ALU operand A.
- ALU_B  input  16  ALU operand B.
- ALU_Q  input  16  ALU result.
- Digits  output  32  eight nibbles; digit k = Digits[4k+3:4k]; digit 7 is leftmost.
- Blank  output  8  Blank[k]=1 means digit k must be shown dark.
- Page  output  2  current page index.

Behaviour:
- Reset (async, ResetN=0): Page=0, Digits=0, Blank=8'hFF, debounce FSM=IDLE, counter=0, synchronizer flops=1 (released).
- Synchronizer: PageBtnN passes through 2 flops; only the synchronized value (btn_s, 1=released) is used downstream.
- Debounce FSM, four states:
  - IDLE: btn_s=0 -> PRESS_WAIT, count cleared.
  - PRESS_WAIT: btn_s=1 -> IDLE. If btn_s=0 and count reaches DEBOUNCE_CYCLES-1 -> HELD, and a 1-cycle advance pulse fires.
  - HELD: btn_s=1 -> RELEASE_WAIT, count cleared.
  - RELEASE_WAIT: btn_s=0 -> HELD. If btn_s=1 and count reaches DEBOUNCE_CYCLES-1 -> IDLE.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - Exactly one advance per accepted press. Holding the button never repeats.
- Page register: on advance, Page <= (Page==NUM_PAGES-1) ? 0 : Page+1.
- Digit map. All digits are registered, so there is 1-cycle latency from inputs and from a Page change to Digits/Blank.
  - Page 0: d7..d6 = PC; d5..d2 = IR; d1 blank; d0 = State.
  - Page 1: d7..d4 = ALU_A; d3..d0 = ALU_B; none blank.
  - Page 2: d7..d4 blank; d3..d0 = ALU_Q.
  - Nibble order within a field is MSB nibble on the left.
  - Blanked digits drive a nibble of 0.
  - An illegal Page value (3) shows all digits blank and forces Page to 0 on the next cycle.
- Button edges during reset are ignored.
- Reset mid-debounce discards the pending press, with no advance.

Optional Feature:
- Macro DISP_FREEZE_EN.
- Defined: adds input port Freeze (1 bit). While Freeze=1, Digits and Blank hold their current values; Page still advances. The first cycle after Freeze falls, Digits and Blank reload from the current page.
- Undefined: no Freeze port; Digits and Blank update every cycle.

Decomposition:
- Shared package disp_pkg holds:
  - typedef page_t (2-bit enum: PG_CTRL=0, PG_OPS=1, PG_RES=2);
  - typedef dbnc_state_t (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - localparam NUM_DIGITS=8.
- One sub-module: btn_debounce, containing the synchronizer, the debounce FSM, the counter and the advance pulse.
- Page register and digit mux stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: release reset with PC=8'h3C, IR=16'hA1F0, State=4'h5 -> 1 cycle later Digits=32'h3CA1F005, Blank=8'h02, Page=0.
- Clean press: hold PageBtnN=0 for 10 cycles, then release for 10 -> exactly one advance, Page=1. With ALU_A=16'h1234, ALU_B=16'hBEEF, the next cycle shows Digits=32'h1234BEEF, Blank=8'h00.
- Bounce: toggle PageBtnN every 2 cycles for 20 cycles, then hold high -> Page unchanged.
- Wrap: three accepted presses from Page=0 -> Page sequence 1,2,0. On Page 2 with ALU_Q=16'h00FF: Digits=32'h000000FF, Blank=8'hF0.
- Reset mid-press: assert ResetN=0 while in PRESS_WAIT -> Page=0, no advance after reset is released, even if the button is still held.
- DISP_FREEZE_EN: Freeze=1, change IR from 16'h0001 to 16'h0002 -> Digits hold the 16'h0001 field. Freeze=0 -> one cycle later Digits show 16'h0002.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types for the display page selector: page codes, debounce FSM
// states and the digit count of the 7-segment bank.
package disp_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        PG_CTRL = 2'd0,
        PG_OPS  = 2'd1,
        PG_RES  = 2'd2
    } page_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM and a
// single-cycle advance pulse per accepted press.
//
// state        | meaning
// -------------+---------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | button seen low, counting stable low samples
// HELD         | press accepted, waiting for the release
// RELEASE_WAIT | button seen high, counting stable high samples
//
// A press that is already held when reset is released is not accepted:
// the FSM stays disarmed until it has seen a genuine released sample,
// i.e. one taken after the synchronizer has flushed its reset value.
module btn_debounce
    import disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic ResetN,
    input  logic PageBtnN,
    output logic advance_o
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          armed_q;
    logic          btn_s;
    dbnc_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign btn_s = sync_q[1];

    // Synchronizer (reset to released) and its flush tracker.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            sync_q  <= 2'b11;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], PageBtnN};
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & btn_s);
        end
    end

    // Debounce FSM state and stable-sample counter.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and advance pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        advance_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!btn_s && armed_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    advance_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/display_page_select.sv
// Debug page selector feeding the eight hex digit decoders. A debounced
// push-button steps through the pages; the selected page is sliced into
// registered nibbles with per-digit blank flags.
// Build option: DISP_FREEZE_EN adds a Freeze input that holds Digits/Blank.
module display_page_select
    import disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_PAGES       = 3
) (
    input  logic                      Clk,
    input  logic                      ResetN,
    input  logic                      PageBtnN,
    input  logic [7:0]                PC,
    input  logic [15:0]               IR,
    input  logic [3:0]                State,
    input  logic [15:0]               ALU_A,
    input  logic [15:0]               ALU_B,
    input  logic [15:0]               ALU_Q,
`ifdef DISP_FREEZE_EN
    input  logic                      Freeze,
`endif
    output logic [4*NUM_DIGITS-1:0]   Digits,
    output logic [NUM_DIGITS-1:0]     Blank,
    output logic [1:0]                Page
);

    localparam logic [1:0] PAGE_LAST = 2'(NUM_PAGES - 1);

    logic                    advance;
    logic [1:0]              page_q, page_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .PageBtnN  (PageBtnN),
        .advance_o (advance)
    );

    // Page index: wrap on advance, recover from an out-of-range code.
    always_comb begin
        page_d = page_q;
        if (page_q > PAGE_LAST) begin
            page_d = 2'd0;
        end else if (advance) begin
            page_d = (page_q == PAGE_LAST) ? 2'd0 : page_q + 2'd1;
        end
    end

    // Digit map for the current page; blanked digits carry a zero nibble.
    always_comb begin
        digits_d = '0;
        blank_d  = '1;
        case (page_t'(page_q))
            PG_CTRL: begin
                digits_d = {PC, IR, 4'h0, State};
                blank_d  = 8'b0000_0010;
            end
            PG_OPS: begin
                digits_d = {ALU_A, ALU_B};
                blank_d  = 8'b0000_0000;
            end
            PG_RES: begin
                digits_d = {16'h0000, ALU_Q};
                blank_d  = 8'b1111_0000;
            end
            default: begin
                digits_d = '0;
                blank_d  = '1;
            end
        endcase
    end

    // Page and output registers.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            page_q   <= 2'd0;
            digits_q <= '0;
            blank_q  <= '1;
        end else begin
            page_q <= page_d;
`ifdef DISP_FREEZE_EN
            if (!Freeze) begin
                digits_q <= digits_d;
                blank_q  <= blank_d;
            end
`else
            digits_q <= digits_d;
            blank_q  <= blank_d;
`endif
        end
    end

    assign Digits = digits_q;
    assign Blank  = blank_q;
    assign Page   = page_q;

endmodule
